// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage and the aux requester, the data-RAM arbiter, and the RAM.
// slave = arbiter side, master = requesters plus RAM side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 30
);
  logic              mem_oe;
  logic              mem_wr;
  logic [31:0]       ma;
  logic [31:0]       mwd;
  logic [31:0]       mrd;
  logic              mem_stall;
  logic              aux_req;
  logic              aux_wr;
  logic [31:0]       aux_addr;
  logic [31:0]       aux_wdata;
  logic              aux_gnt;
  logic              aux_done;
  logic [31:0]       aux_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  mem_oe, mem_wr, ma, mwd, aux_req, aux_wr, aux_addr, aux_wdata, ram_rdata,
    output mrd, mem_stall, aux_gnt, aux_done, aux_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output mem_oe, mem_wr, ma, mwd, aux_req, aux_wr, aux_addr, aux_wdata, ram_rdata,
    input  mrd, mem_stall, aux_gnt, aux_done, aux_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter: MEM pipeline (priority) vs. aux loader port, fixed wait states.
// Optional anti-starvation guard for the aux port: define STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int WAIT_STATES  = 1,
  parameter int ADDR_W       = 30,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic [2:0]    state_o
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] P_ACC  = 3'd1;
  localparam logic [2:0] P_DONE = 3'd2;
  localparam logic [2:0] A_ACC  = 3'd3;
  localparam logic [2:0] A_DONE = 3'd4;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       mrd_q, mrd_d;
  logic [31:0]       aux_rdata_q, aux_rdata_d;
  logic              pipe_req;
  logic              force_aux;
  logic              unused_addr_bits;

  assign pipe_req         = bus.mem_oe | bus.mem_wr;
  assign unused_addr_bits = &{1'b0, bus.ma[1:0], bus.aux_addr[1:0]};

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign force_aux = bus.aux_req && (starve_q == SW'(STARVE_LIMIT));

  // Counts pipe grants made while aux waits; any aux grant or idle aux clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!bus.aux_req)                starve_d = '0;
      else if (pipe_req && !force_aux) starve_d = starve_q + 1'b1;
      else                             starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  localparam bit unused_starve_limit = (STARVE_LIMIT > 0);
  assign force_aux = 1'b0;
`endif

  // Handshake: requests are levels sampled only in IDLE; the pipeline holds its request
  // while mem_stall=1, aux holds until aux_done and must drop aux_req in that cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    mrd_d       = mrd_q;
    aux_rdata_d = aux_rdata_q;
    case (state_q)
      IDLE: begin
        if (pipe_req && !force_aux) begin
          state_d     = P_ACC;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.mem_wr;
          ram_addr_d  = bus.ma[ADDR_W+1:2];
          ram_wdata_d = bus.mwd;
          cnt_d       = WS;
        end else if (bus.aux_req) begin
          state_d     = A_ACC;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.aux_wr;
          ram_addr_d  = bus.aux_addr[ADDR_W+1:2];
          ram_wdata_d = bus.aux_wdata;
          cnt_d       = WS;
        end
      end
      P_ACC, A_ACC: begin
        if (cnt_q == 4'd0) begin
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          if (!ram_we_q) begin
            if (state_q == P_ACC) mrd_d       = bus.ram_rdata;
            else                  aux_rdata_d = bus.ram_rdata;
          end
          state_d = (state_q == P_ACC) ? P_DONE : A_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'd0;
      mrd_q       <= 32'd0;
      aux_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      mrd_q       <= mrd_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  // rst_n gate keeps the stall low while reset is held, even with a live request.
  assign bus.mem_stall = rst_n & pipe_req & (state_q != P_DONE);
  assign bus.mrd       = mrd_q;
  assign bus.aux_rdata = aux_rdata_q;
  assign bus.aux_gnt   = (state_q == A_ACC);
  assign bus.aux_done  = (state_q == A_DONE);
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random bench for dmem_arbiter with a behavioural RAM and an expected-data queue.
module tb_dmem_arbiter;
  localparam int         WS      = 1;
  localparam int         AW      = 30;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PDONE = 3'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state_o;

  dmem_arbiter_if #(.ADDR_W(AW)) bus ();

  dmem_arbiter #(.WAIT_STATES(WS), .ADDR_W(AW), .STARVE_LIMIT(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model and reference contents ----------------
  logic [31:0] ram_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_q [$];
  logic [31:0] last_mrd;
  int tests = 0;
  int fails = 0;

  assign bus.ram_rdata = ram_mem[bus.ram_addr[7:0]];
  always @(posedge clk) if (bus.ram_en && bus.ram_we) ram_mem[bus.ram_addr[7:0]] <= bus.ram_wdata;

  function automatic logic [31:0] init_word(int i);
    return {8'(i), 8'(~i), 8'(i * 3), 8'hC3};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs, output logic [31:0] e);
    e = 32'd0;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed 0x%08h expected <none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pipe_access(input logic oe, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input string tag);
    logic [31:0] wa;
    logic [31:0] e;
    wa = {2'b00, addr[31:2]};
    @(negedge clk);
    bus.mem_oe = oe; bus.mem_wr = wr; bus.ma = addr; bus.mwd = wd;
    if (wr) ref_mem[addr[9:2]] = wd;
    else    exp_q.push_back(ref_mem[addr[9:2]]);
    #1;
    check({tag, "_stall_c0"}, 32'(bus.mem_stall), 32'd1);
    check({tag, "_en_c0"}, 32'(bus.ram_en), 32'd0);
    for (int c = 1; c <= WS + 1; c++) begin
      @(negedge clk);
      check({tag, "_en"}, 32'(bus.ram_en), 32'd1);
      check({tag, "_we"}, 32'(bus.ram_we), 32'(wr));
      check({tag, "_addr"}, 32'(bus.ram_addr), wa);
      check({tag, "_stall"}, 32'(bus.mem_stall), 32'd1);
      if (wr) check({tag, "_wdata"}, bus.ram_wdata, wd);
    end
    @(negedge clk);
    check({tag, "_stall_done"}, 32'(bus.mem_stall), 32'd0);
    check({tag, "_en_done"}, 32'(bus.ram_en), 32'd0);
    check({tag, "_state_done"}, 32'(state_o), 32'(S_PDONE));
    if (wr) check({tag, "_mrd_kept"}, bus.mrd, last_mrd);
    else begin
      pop_check({tag, "_mrd"}, bus.mrd, e);
      last_mrd = e;
    end
    bus.mem_oe = 1'b0; bus.mem_wr = 1'b0;
  endtask

  task automatic aux_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input string tag);
    logic [31:0] e;
    @(negedge clk);
    bus.aux_req = 1'b1; bus.aux_wr = wr; bus.aux_addr = addr; bus.aux_wdata = wd;
    if (wr) ref_mem[addr[9:2]] = wd;
    else    exp_q.push_back(ref_mem[addr[9:2]]);
    #1;
    check({tag, "_gnt_c0"}, 32'(bus.aux_gnt), 32'd0);
    for (int c = 1; c <= WS + 1; c++) begin
      @(negedge clk);
      check({tag, "_gnt"}, 32'(bus.aux_gnt), 32'd1);
      check({tag, "_en"}, 32'(bus.ram_en), 32'd1);
      check({tag, "_we"}, 32'(bus.ram_we), 32'(wr));
      check({tag, "_addr"}, 32'(bus.ram_addr), {2'b00, addr[31:2]});
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(bus.aux_done), 32'd1);
    check({tag, "_gnt_end"}, 32'(bus.aux_gnt), 32'd0);
    if (!wr) pop_check({tag, "_rdata"}, bus.aux_rdata, e);
    bus.aux_req = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.aux_done), 32'd0);
  endtask

  task automatic wait_aux_done(input string tag, input int budget);
    logic [31:0] e;
    int n;
    n = 0;
    while (!bus.aux_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (bus.aux_done === 1'b1) else begin
      fails++;
      $error("FAIL %s_timeout: observed aux_done=%0b after %0d cycles expected 1", tag, bus.aux_done, n);
    end
    if (bus.aux_done) pop_check({tag, "_rdata"}, bus.aux_rdata, e);
    bus.aux_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, gnt_cycles, pdone_before, done_seen;
    logic first_gnt, seen_done;
    logic [31:0] e, ra, wd;

    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    ram_mem[8'h40] = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;
    last_mrd = 32'd0;
    rst_n = 1'b0;
    bus.mem_oe = 1'b0; bus.mem_wr = 1'b0; bus.ma = 32'd0; bus.mwd = 32'd0;
    bus.aux_req = 1'b0; bus.aux_wr = 1'b0; bus.aux_addr = 32'd0; bus.aux_wdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mrd", bus.mrd, 32'd0);
    check("rst_aux_rdata", bus.aux_rdata, 32'd0);
    check("rst_ram_en", 32'(bus.ram_en), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    rst_n = 1'b1;

    // 1: pipe read of 0x100 -> word 0x40
    pipe_access(1'b1, 1'b0, 32'h100, 32'd0, "t1_rd");
    @(negedge clk);
    check("t1_mrd_hold", bus.mrd, 32'hDEADBEEF);

    // 2: pipe write, readback via aux; oe+wr together is a write with mrd unchanged
    pipe_access(1'b0, 1'b1, 32'h8, 32'h12345678, "t2_wr");
    aux_access(1'b0, 32'h8, 32'd0, "t2_aux_rb");
    pipe_access(1'b1, 1'b1, 32'h10, 32'hA5A55A5A, "t2_oewr");
    aux_access(1'b0, 32'h10, 32'd0, "t2_aux_rb2");

    // 3: aux read alone, aux write then pipe readback
    aux_access(1'b0, 32'h20, 32'd0, "t3_aux_rd");
    aux_access(1'b1, 32'h24, 32'h0BADF00D, "t3_aux_wr");
    pipe_access(1'b1, 1'b0, 32'h24, 32'd0, "t3_pipe_rb");

    // 4: simultaneous requests, pipe wins
    @(negedge clk);
    bus.aux_req = 1'b1; bus.aux_wr = 1'b0; bus.aux_addr = 32'h44;
    bus.mem_oe = 1'b1; bus.ma = 32'h48;
    exp_q.push_back(ref_mem[8'h12]);
    exp_q.push_back(ref_mem[8'h11]);
    for (int c = 1; c <= WS + 1; c++) begin
      @(negedge clk);
      check("t4_gnt_during_pipe", 32'(bus.aux_gnt), 32'd0);
      check("t4_pipe_addr", 32'(bus.ram_addr), 32'h12);
    end
    @(negedge clk);
    check("t4_pdone_stall", 32'(bus.mem_stall), 32'd0);
    pop_check("t4_mrd", bus.mrd, e);
    bus.mem_oe = 1'b0;
    @(negedge clk);
    check("t4_gnt_idle", 32'(bus.aux_gnt), 32'd0);
    @(negedge clk);
    check("t4_gnt_after", 32'(bus.aux_gnt), 32'd1);
    check("t4_aux_addr", 32'(bus.ram_addr), 32'h11);
    wait_aux_done("t4_aux", 10);

    // 5: pipe request arrives mid aux access
    @(negedge clk);
    bus.aux_req = 1'b1; bus.aux_wr = 1'b0; bus.aux_addr = 32'h30;
    exp_q.push_back(ref_mem[8'h0C]);
    @(negedge clk);
    check("t5_aux_gnt", 32'(bus.aux_gnt), 32'd1);
    bus.mem_oe = 1'b1; bus.ma = 32'h34;
    exp_q.push_back(ref_mem[8'h0D]);
    #1;
    n = 0;
    seen_done = 1'b0;
    while (bus.mem_stall && n < 20) begin
      n++;
      @(negedge clk);
      if (bus.aux_done) begin
        pop_check("t5_aux_rdata", bus.aux_rdata, e);
        bus.aux_req = 1'b0;
        seen_done = 1'b1;
      end
    end
    check("t5_stall_cycles", 32'(n), 32'(2 * WS + 4));
    check("t5_aux_done_seen", 32'(seen_done), 32'd1);
    pop_check("t5_mrd", bus.mrd, e);
    bus.mem_oe = 1'b0;
    bus.aux_req = 1'b0;

    // 6: pipe held continuously with aux waiting
    @(negedge clk);
    bus.mem_oe = 1'b1; bus.ma = 32'h40; bus.aux_req = 1'b1; bus.aux_wr = 1'b0; bus.aux_addr = 32'h4;
    gnt_cycles = 0; pdone_before = 0; first_gnt = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.aux_gnt) begin
        gnt_cycles++;
        first_gnt = 1'b1;
      end
      if (state_o == S_PDONE && !first_gnt) pdone_before++;
      if (bus.aux_done) bus.aux_req = 1'b0;
    end
    bus.mem_oe = 1'b0; bus.aux_req = 1'b0;
`ifdef STARVE_GUARD_EN
    check("t6_pipe_before_aux", 32'(pdone_before), 32'd8);
    check("t6_aux_gnt_cycles", 32'(gnt_cycles), 32'(WS + 1));
`else
    check("t6_aux_starved", 32'(gnt_cycles), 32'd0);
    check("t6_pipe_accesses", 32'(pdone_before), 32'd15);
`endif
    repeat (4) @(negedge clk);

    // 7: reset in the middle of an aux access
    @(negedge clk);
    bus.aux_req = 1'b1; bus.aux_wr = 1'b1; bus.aux_addr = 32'h50; bus.aux_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("t7_gnt_pre", 32'(bus.aux_gnt), 32'd1);
    bus.mem_oe = 1'b1; bus.ma = 32'h60;
    rst_n = 1'b0;
    #1;
    check("t7_rst_gnt", 32'(bus.aux_gnt), 32'd0);
    check("t7_rst_en", 32'(bus.ram_en), 32'd0);
    check("t7_rst_we", 32'(bus.ram_we), 32'd0);
    check("t7_rst_addr", 32'(bus.ram_addr), 32'd0);
    check("t7_rst_wdata", bus.ram_wdata, 32'd0);
    check("t7_rst_stall", 32'(bus.mem_stall), 32'd0);
    check("t7_rst_mrd", bus.mrd, 32'd0);
    check("t7_rst_aux_rdata", bus.aux_rdata, 32'd0);
    check("t7_rst_state", 32'(state_o), 32'(S_IDLE));
    bus.aux_req = 1'b0; bus.mem_oe = 1'b0;
    last_mrd = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.aux_done) done_seen++;
    end
    check("t7_no_aux_done", 32'(done_seen), 32'd0);

    // 8: random mix of accesses
    for (int i = 0; i < 10; i++) begin
      ra = 32'($urandom_range(0, 255)) << 2;
      wd = $urandom;
      case ($urandom_range(0, 3))
        0: pipe_access(1'b1, 1'b0, ra, 32'd0, "r_pipe_rd");
        1: pipe_access(1'b0, 1'b1, ra, wd, "r_pipe_wr");
        2: aux_access(1'b0, ra, 32'd0, "r_aux_rd");
        default: aux_access(1'b1, ra, wd, "r_aux_wr");
      endcase
    end
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
